cb_fifo_arb: RTL and testbench
==============================

CB_FIFO_ARB -- requirements
Module: cb_fifo_arb

Interface
REQ-001 SHALL have parameter Data_W, default 32: width of each data beat.
REQ-002 SHALL have parameter NUM_REQ, default 4 (legal 2..16): number of requesters sharing one downstream credit-based FIFO.
REQ-003 SHALL have parameter CREDITS, default 8: downstream FIFO depth, which is also the initial credit count.
REQ-004 SHALL define SRC_W = max(1, clog2(NUM_REQ)) and CRD_W = clog2(CREDITS+1).
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 req_valid  input  NUM_REQ  per-requester beat valid.
REQ-008 req_ready  output  NUM_REQ  per-requester accept; at most one bit high per cycle.
REQ-009 req_data  input  NUM_REQ*Data_W  requester i occupies bits [i*Data_W +: Data_W].
REQ-010 req_last  input  NUM_REQ  marks final beat of requester i's packet.
REQ-011 m_valid  output  1  registered one-cycle push strobe to the FIFO; the FIFO never backpressures.
REQ-012 m_data  output  Data_W  registered beat data.
REQ-013 m_last  output  1  registered last flag.
REQ-014 m_src  output  SRC_W  registered index of the source requester.
REQ-015 credit_ret  input  1  one-cycle pulse per FIFO pop; returns one credit.
REQ-016 credits  output  CRD_W  current credit count.
REQ-017 busy  output  1  high while in LOCKED.
REQ-018 credit_err  output  1  sticky; set on credit overflow.

Function
REQ-019 SHALL implement a two-state FSM: IDLE (no packet owner) and LOCKED (owner register holds the granted index).
REQ-020 IDLE: winner = first i with req_valid[i]=1, searching from rr_ptr upward modulo NUM_REQ; req_ready[winner] = (credits != 0); all other ready bits 0.
REQ-021 LOCKED: req_ready[owner] = (credits != 0); all other ready bits 0, whatever their valid.
REQ-022 A beat is accepted when req_valid[i] && req_ready[i]; req_ready SHALL be combinational from the current state, credits and req_valid, and independent of credit_ret.
REQ-023 Accepted beat, IDLE, req_last=0: go to LOCKED with owner = i.
REQ-024 Accepted beat with req_last=1 (either state): go to (or stay in) IDLE, with rr_ptr = (i+1) mod NUM_REQ.
REQ-025 credits == 0: no beat accepted; state, owner and rr_ptr hold; arbitration does not advance.
REQ-026 The cycle after an accepted beat: m_valid=1, m_data = accepted data, m_last = accepted last, m_src = i; one cycle of latency.
REQ-027 m_valid SHALL be 0 in any cycle not preceded by an accepted beat; m_data, m_last and m_src hold their last value.
REQ-028 credits_next = credits - accept + credit_ret; a simultaneous accept and return leaves credits unchanged.
REQ-029 If credit_ret=1 with no accept while credits == CREDITS: credits holds at CREDITS and credit_err is set until reset.
REQ-030 credits SHALL never decrement below 0; this holds by construction from REQ-020/021.
REQ-031 The bench SHALL assert the following each cycle: popcount(req_ready) <= 1; credits <= CREDITS; m_valid implies the previous cycle had credits > 0.
REQ-032 A requester dropping req_valid mid-packet in LOCKED SHALL NOT release ownership; the lock holds until its last beat is accepted.

Reset
REQ-033 While rst=1 at a clock edge, SHALL load: state=IDLE, rr_ptr=0, owner=0, credits=CREDITS, m_valid=0, m_data=0, m_last=0, m_src=0, credit_err=0.
REQ-034 Reset asserted mid-packet SHALL drop the lock with no further m_valid; in-flight FIFO contents are not tracked, and credits return to CREDITS.
REQ-035 While rst=1, req_ready SHALL be all-zero.

Verification
REQ-036 Round-robin: all 4 requesters valid with single-beat packets (last=1), credit_ret tied 1 -> m_src sequence 0,1,2,3,0 on consecutive cycles.
REQ-037 Packet lock: req0 sends a 3-beat packet while req1 is valid throughout -> m_src = 0,0,0 then 1; req_ready[1]=0 during the lock.
REQ-038 Credit exhaustion: CREDITS=8, no credit_ret, req0 streaming -> exactly 8 m_valid pulses, then credits=0 and req_ready=0; one credit_ret pulse -> exactly one more beat.
REQ-039 Simultaneous accept and credit_ret at credits=3 -> credits stays 3; credit_ret at credits=8 with no accept -> credits=8 and credit_err=1.
REQ-040 Reset mid-packet: rst during beat 2 of 4 from req2 -> next cycle credits=8, busy=0, m_valid=0; next grant searches from index 0.

Source files
------------

// File: rtl/cb_fifo_arb_if.sv
// cb_fifo_arb_if: requester/FIFO bundle (req_valid/ready/data/last in, m_valid/data/last/src push out, credit_ret in, credits/busy/credit_err status)
interface cb_fifo_arb_if #(
  parameter int Data_W  = 32,
  parameter int NUM_REQ = 4,
  parameter int CREDITS = 8
);
  localparam int SRC_W = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int CRD_W = $clog2(CREDITS + 1);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*Data_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic                      m_valid;
  logic [Data_W-1:0]         m_data;
  logic                      m_last;
  logic [SRC_W-1:0]          m_src;
  logic                      credit_ret;
  logic [CRD_W-1:0]          credits;
  logic                      busy;
  logic                      credit_err;
  modport master (
    output req_valid, req_data, req_last, credit_ret,
    input  req_ready, m_valid, m_data, m_last, m_src, credits, busy, credit_err
  );
  modport slave (
    input  req_valid, req_data, req_last, credit_ret,
    output req_ready, m_valid, m_data, m_last, m_src, credits, busy, credit_err
  );
endinterface

// File: rtl/cb_fifo_arb.sv
// cb_fifo_arb: round-robin packet-locking arbiter into a credit-based FIFO; ports clk, rst (sync, high), bus (cb_fifo_arb_if.slave)
module cb_fifo_arb #(
  parameter int Data_W  = 32,
  parameter int NUM_REQ = 4,
  parameter int CREDITS = 8
) (
  input logic clk,
  input logic rst,
  cb_fifo_arb_if.slave bus
);
  localparam int SRC_W = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int CRD_W = $clog2(CREDITS + 1);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t             r_state;
  logic [SRC_W-1:0]   r_owner;
  logic [SRC_W-1:0]   r_rr_ptr;
  logic [CRD_W-1:0]   r_credits;
  logic               r_m_valid;
  logic [Data_W-1:0]  r_m_data;
  logic               r_m_last;
  logic [SRC_W-1:0]   r_m_src;
  logic               r_credit_err;
  logic               w_found;
  logic [SRC_W-1:0]   w_win;
  logic [SRC_W-1:0]   w_sel;
  logic               w_grant;
  logic               w_acc;
  logic               w_last;
  int unsigned        w_j;
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_j     = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_j = (int'(r_rr_ptr) + k) % NUM_REQ;
      if (bus.req_valid[w_j]) begin
        w_found = 1'b1;
        w_win   = SRC_W'(w_j);
      end
    end
  end
  assign w_sel         = r_state == LOCKED ? r_owner : w_win;
  assign w_grant       = !rst && r_credits != '0 && (r_state == LOCKED || w_found);
  assign w_acc         = w_grant && bus.req_valid[w_sel];
  assign w_last        = bus.req_last[w_sel];
  assign bus.req_ready = w_grant ? NUM_REQ'(1) << w_sel : '0;
  assign bus.m_valid   = r_m_valid;
  assign bus.m_data    = r_m_data;
  assign bus.m_last    = r_m_last;
  assign bus.m_src     = r_m_src;
  assign bus.credits   = r_credits;
  assign bus.busy      = r_state == LOCKED;
  assign bus.credit_err = r_credit_err;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_owner      <= '0;
      r_rr_ptr     <= '0;
      r_credits    <= CRD_W'(CREDITS);
      r_m_valid    <= 1'b0;
      r_m_data     <= '0;
      r_m_last     <= 1'b0;
      r_m_src      <= '0;
      r_credit_err <= 1'b0;
    end else begin
      r_m_valid <= w_acc;
      if (w_acc) begin
        r_m_data <= bus.req_data[w_sel*Data_W +: Data_W];
        r_m_last <= w_last;
        r_m_src  <= w_sel;
        r_state  <= w_last ? IDLE : LOCKED;
        r_owner  <= w_sel;
        if (w_last) r_rr_ptr <= w_sel == SRC_W'(NUM_REQ - 1) ? '0 : w_sel + 1'b1;
      end
      if (w_acc && !bus.credit_ret) r_credits <= r_credits - 1'b1;
      else if (!w_acc && bus.credit_ret) begin
        if (r_credits == CRD_W'(CREDITS)) r_credit_err <= 1'b1;
        else r_credits <= r_credits + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_cb_fifo_arb.sv
// tb_cb_fifo_arb: directed vector table plus corner-case sequences for cb_fifo_arb
module tb_cb_fifo_arb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int pass = 0;
  logic armed = 1'b0;
  logic [3:0] prev_cr = 4'd8;
  int n;
  always #5 clk = ~clk;
  cb_fifo_arb_if #(.Data_W(32), .NUM_REQ(4), .CREDITS(8)) bus ();
  cb_fifo_arb #(.Data_W(32), .NUM_REQ(4), .CREDITS(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    logic       rst;
    logic [3:0] v;
    logic [3:0] l;
    logic       cr;
    logic [3:0] rdy;
    logic       mv;
    logic [1:0] src;
    logic [3:0] crd;
    logic       busy;
  } vec_t;
  vec_t tv [14];
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (armed) begin
      chk("ready_onehot", 32'($countones(bus.req_ready) <= 1), 32'd1);
      chk("credits_max", 32'(bus.credits <= 4'd8), 32'd1);
      chk("mv_had_credit", 32'(bus.m_valid && prev_cr == 4'd0), 32'd0);
      prev_cr <= bus.credits;
    end
  end
  initial begin
    bus.req_valid  = '0;
    bus.req_last   = '0;
    bus.credit_ret = 1'b0;
    for (int i = 0; i < 4; i++) bus.req_data[i*32 +: 32] = 32'hD000_0000 | i;
    tv[0]  = '{1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 4'd8, 1'b0};
    tv[1]  = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 4'd8, 1'b0};
    tv[2]  = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 4'd8, 1'b0};
    tv[3]  = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 4'd8, 1'b0};
    tv[4]  = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 4'd8, 1'b0};
    tv[5]  = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 4'd8, 1'b0};
    tv[6]  = '{1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 4'd8, 1'b0};
    tv[7]  = '{1'b0, 4'b0011, 4'b0000, 1'b0, 4'b0001, 1'b1, 2'd0, 4'd7, 1'b1};
    tv[8]  = '{1'b0, 4'b0011, 4'b0000, 1'b0, 4'b0001, 1'b1, 2'd0, 4'd6, 1'b1};
    tv[9]  = '{1'b0, 4'b0010, 4'b0000, 1'b0, 4'b0001, 1'b0, 2'd0, 4'd6, 1'b1};
    tv[10] = '{1'b0, 4'b0011, 4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0, 4'd5, 1'b0};
    tv[11] = '{1'b0, 4'b0010, 4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1, 4'd4, 1'b0};
    tv[12] = '{1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1, 4'd5, 1'b0};
    tv[13] = '{1'b0, 4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 4'd5, 1'b0};
    repeat (2) @(posedge clk);
    #1;
    armed = 1'b1;
    for (int i = 0; i < 14; i++) begin
      rst = tv[i].rst;
      bus.req_valid = tv[i].v;
      bus.req_last = tv[i].l;
      bus.credit_ret = tv[i].cr;
      #1;
      chk($sformatf("v%0d_ready", i), 32'(bus.req_ready), 32'(tv[i].rdy));
      step();
      chk($sformatf("v%0d_m_valid", i), 32'(bus.m_valid), 32'(tv[i].mv));
      chk($sformatf("v%0d_m_src", i), 32'(bus.m_src), 32'(tv[i].src));
      chk($sformatf("v%0d_credits", i), 32'(bus.credits), 32'(tv[i].crd));
      chk($sformatf("v%0d_busy", i), 32'(bus.busy), 32'(tv[i].busy));
      chk($sformatf("v%0d_err", i), 32'(bus.credit_err), 32'd0);
      if (tv[i].mv) chk($sformatf("v%0d_m_data", i), bus.m_data, 32'hD000_0000 | 32'(tv[i].src));
    end
    rst = 1'b1; bus.req_valid = '0; bus.req_last = '0; bus.credit_ret = 1'b0;
    step();
    rst = 1'b0; bus.req_valid = 4'b0001; bus.req_last = 4'b0001;
    n = 0;
    repeat (12) begin step(); if (bus.m_valid) n++; end
    chk("exhaust_pulses", 32'(n), 32'd8);
    chk("exhaust_credits", 32'(bus.credits), 32'd0);
    chk("exhaust_ready", 32'(bus.req_ready), 32'd0);
    bus.credit_ret = 1'b1;
    step();
    bus.credit_ret = 1'b0;
    n = 0;
    repeat (5) begin step(); if (bus.m_valid) n++; end
    chk("refill_pulses", 32'(n), 32'd1);
    chk("refill_credits", 32'(bus.credits), 32'd0);
    rst = 1'b1; bus.req_valid = '0;
    step();
    rst = 1'b0; bus.req_valid = 4'b0001; bus.req_last = 4'b0001;
    repeat (5) step();
    chk("sim_pre_credits", 32'(bus.credits), 32'd3);
    bus.credit_ret = 1'b1;
    step();
    chk("sim_credits", 32'(bus.credits), 32'd3);
    chk("sim_m_valid", 32'(bus.m_valid), 32'd1);
    rst = 1'b1; bus.req_valid = '0; bus.credit_ret = 1'b0;
    step();
    rst = 1'b0; bus.credit_ret = 1'b1;
    step();
    chk("ovf_credits", 32'(bus.credits), 32'd8);
    chk("ovf_err", 32'(bus.credit_err), 32'd1);
    bus.credit_ret = 1'b0;
    step();
    chk("ovf_err_sticky", 32'(bus.credit_err), 32'd1);
    rst = 1'b1;
    step();
    chk("ovf_err_cleared", 32'(bus.credit_err), 32'd0);
    rst = 1'b0; bus.req_valid = 4'b0100; bus.req_last = 4'b0000; bus.credit_ret = 1'b1;
    step();
    chk("mid_busy", 32'(bus.busy), 32'd1);
    chk("mid_src", 32'(bus.m_src), 32'd2);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(bus.req_ready), 32'd0);
    step();
    chk("mid_credits", 32'(bus.credits), 32'd8);
    chk("mid_busy_drop", 32'(bus.busy), 32'd0);
    chk("mid_m_valid", 32'(bus.m_valid), 32'd0);
    rst = 1'b0; bus.req_valid = 4'b0101; bus.req_last = 4'b0101; bus.credit_ret = 1'b0;
    #1;
    chk("post_rst_ready", 32'(bus.req_ready), 32'd1);
    step();
    chk("post_rst_src", 32'(bus.m_src), 32'd0);
    chk("post_rst_mv", 32'(bus.m_valid), 32'd1);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
